dma_clk_gate_ctrl: RTL and testbench
====================================

// Module: dma_clk_gate_ctrl
// PURPOSE
// - Power-management controller that drives the enable / wait_r inputs of the DMA clock gater.
// - Watches DMA activity and, after a programmable idle window, negotiates sleep with the engine
//   (sleep_req/sleep_ack). It then gates the clock and restores it with a settle delay on wake.
// - Runs on the free-running clk, never on gclk. Sits beside the clock gater in the DMA top.
// PARAMETERS
// - NUM_SRC      4   width of the activity vector (channel requests / busy flags)
// - IDLE_CYCLES  16  consecutive idle cycles before requesting sleep; legal range >=1
// - WAKE_CYCLES  4   cycles enable is high with wait_r still high before gclk resumes; legal range >=1
// - CNT_W        8   width of the saturating sleep-entry counter
// PORTS
// - clk        in   1        free-running system clock
// - rst        in   1        synchronous, active-high reset
// - ctrl_en    in   1        auto-gating enable; 0 forces the clock on
// - activity   in   NUM_SRC  any bit high = DMA work pending/in progress
// - wake_req   in   1        external wake (CPU register access, debug)
// - sleep_ack  in   1        engine quiesced, safe to stop gclk
// - enable     out  1        to clock gater enable
// - wait_r     out  1        to clock gater wait_r (1 blocks gclk)
// - sleep_req  out  1        request to engine to quiesce
// - awake      out  1        1 in RUN/IDLE/REQ
// - gate_cnt   out  CNT_W    number of SLEEP entries, saturating at all-ones
// BEHAVIOUR
// - All outputs registered. wake_ev = |activity | wake_req | ~ctrl_en.
// - Reset (sync, rst=1 at an edge): state=RUN, enable=1, wait_r=0, sleep_req=0, awake=1,
//   gate_cnt=0, counter=0. Reset mid-sleep restores the clock on the next edge.
// - RUN: enable=1, wait_r=0. If ~wake_ev -> IDLE, counter<=IDLE_CYCLES-1.
// - IDLE: outputs as RUN. wake_ev -> RUN. Else if counter==0 -> REQ. Else counter--.
// - REQ: sleep_req=1, enable=1, wait_r=0.
//   - wake_ev -> RUN and sleep_req drops. wake_ev has priority over sleep_ack.
//   - Else if sleep_ack -> SLEEP and gate_cnt++ (saturating).
// - SLEEP: enable=0, wait_r=1, sleep_req=1, awake=0.
//   - wake_ev -> WAKE, counter<=WAKE_CYCLES-1, sleep_req=0, enable=1, wait_r=1.
// - WAKE: enable=1, wait_r=1, awake=0. wake_ev is ignored.
//   - counter==0 -> RUN (wait_r=0). Else counter--.
// - Latency, idle from cycle 0 with ctrl_en=1:
//   - IDLE at edge 1; sleep_req high after edge 1+IDLE_CYCLES.
//   - enable low one edge after sleep_ack is sampled in REQ.
// - Wake latency: wake_ev sampled at edge k -> enable=1 after k; wait_r=0 after k+WAKE_CYCLES.
// - Gater is never shown enable=0 with wait_r=0. Both outputs change on the same edge.
// - sleep_ack outside REQ is ignored. A pulse of activity during IDLE restarts the full window.
// - gate_cnt holds at 2^CNT_W-1. It is cleared only by rst.
// STRUCTURE
// - dma_pm_pkg: state encoding localparams (RUN, IDLE, REQ, SLEEP, WAKE; 3-bit binary) and a
//   function computing counter width from max(IDLE_CYCLES, WAKE_CYCLES).
// - Sub-module pm_down_counter: loadable down counter with zero flag, shared by IDLE and WAKE.
// - Top: FSM + output registers + saturating gate_cnt.
// TESTING
// - Reset: rst=1 while in SLEEP -> next edge enable=1, wait_r=0, sleep_req=0, gate_cnt=0.
// - Idle entry: defaults, activity=0 from cycle 0 -> sleep_req=1 at cycle 17. Drive sleep_ack=1 at
//   cycle 19 -> enable=0, wait_r=1 at cycle 20, gate_cnt=1.
// - Abort: in REQ drive activity=4'b0010 and sleep_ack=1 together -> RUN, enable stays 1,
//   sleep_req=0, gate_cnt unchanged.
// - Wake: wake_req pulse at cycle k in SLEEP -> enable=1 at k+1, wait_r=1 through k+4, wait_r=0 at
//   k+5, awake=1 at k+5.
// - Idle restart: activity pulse at idle cycle 10 -> sleep_req delayed until 16 further idle cycles.
// - Saturation/override: CNT_W=2, force 5 sleeps -> gate_cnt=3. ctrl_en=0 in SLEEP -> WAKE and never
//   re-enters IDLE while ctrl_en=0.

Source files
------------

// File: rtl/dma_pm_pkg.sv
// ============================================================================
// dma_pm_pkg
// Power-management FSM state encoding and counter sizing helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dma_pm_pkg;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_REQ   = 3'd2,
    ST_SLEEP = 3'd3,
    ST_WAKE  = 3'd4
  } pm_state_e;

  // Counter only ever holds window-1, so the larger window sets the width.
  function automatic int pm_cnt_width(input int idle_cycles, input int wake_cycles);
    int max_win;
    max_win = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
    return (max_win <= 1) ? 1 : $clog2(max_win);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pm_down_counter.sv
// ============================================================================
// pm_down_counter
// Loadable down counter with zero flag, shared by the idle and wake windows.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pm_down_counter
  import dma_pm_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/dma_clk_gate_ctrl.sv
// ============================================================================
// dma_clk_gate_ctrl
// Idle-driven sleep negotiation and clock-gater enable/wait_r sequencing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dma_clk_gate_ctrl
  import dma_pm_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ctrl_en,
  input  logic [NUM_SRC-1:0] activity,
  input  logic               wake_req,
  input  logic               sleep_ack,
  output logic               enable,
  output logic               wait_r,
  output logic               sleep_req,
  output logic               awake,
  output logic [CNT_W-1:0]   gate_cnt
);

  localparam int CTR_W = pm_cnt_width(IDLE_CYCLES, WAKE_CYCLES);
  localparam logic [CTR_W-1:0] c_idle_load = CTR_W'(IDLE_CYCLES - 1);
  localparam logic [CTR_W-1:0] c_wake_load = CTR_W'(WAKE_CYCLES - 1);

  pm_state_e        state_q, state_d;
  logic             enable_q, enable_d;
  logic             wait_r_q, wait_r_d;
  logic             sleep_req_q, sleep_req_d;
  logic             awake_q, awake_d;
  logic [CNT_W-1:0] gate_cnt_q, gate_cnt_d;

  logic             wake_ev;
  logic             cnt_load;
  logic [CTR_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;

  assign wake_ev = (|activity) | wake_req | ~ctrl_en;

  pm_down_counter #(
    .W (CTR_W)
  ) u_win_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    gate_cnt_d   = gate_cnt_q;

    case (state_q)
      ST_RUN: begin
        if (!wake_ev) begin
          state_d      = ST_IDLE;
          cnt_load     = 1'b1;
          cnt_load_val = c_idle_load;
        end
      end
      ST_IDLE: begin
        if (wake_ev) begin
          state_d = ST_RUN;
        end else if (cnt_zero) begin
          state_d = ST_REQ;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_REQ: begin
        // Fresh work wins over a late acknowledge so no request is stranded.
        if (wake_ev) begin
          state_d = ST_RUN;
        end else if (sleep_ack) begin
          state_d = ST_SLEEP;
          if (gate_cnt_q != '1) begin
            gate_cnt_d = gate_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_SLEEP: begin
        if (wake_ev) begin
          state_d      = ST_WAKE;
          cnt_load     = 1'b1;
          cnt_load_val = c_wake_load;
        end
      end
      ST_WAKE: begin
        if (cnt_zero) begin
          state_d = ST_RUN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Outputs decode the next state so they switch on the same edge as it.
    enable_d    = (state_d != ST_SLEEP);
    wait_r_d    = (state_d == ST_SLEEP) || (state_d == ST_WAKE);
    sleep_req_d = (state_d == ST_REQ) || (state_d == ST_SLEEP);
    awake_d     = (state_d == ST_RUN) || (state_d == ST_IDLE) || (state_d == ST_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      enable_q    <= 1'b1;
      wait_r_q    <= 1'b0;
      sleep_req_q <= 1'b0;
      awake_q     <= 1'b1;
      gate_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      wait_r_q    <= wait_r_d;
      sleep_req_q <= sleep_req_d;
      awake_q     <= awake_d;
      gate_cnt_q  <= gate_cnt_d;
    end
  end

  assign enable    = enable_q;
  assign wait_r    = wait_r_q;
  assign sleep_req = sleep_req_q;
  assign awake     = awake_q;
  assign gate_cnt  = gate_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_clk_gate_ctrl.sv
// ============================================================================
// tb_dma_clk_gate_ctrl
// Directed bench with a cycle-count behavioural model and literal checkpoints.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dma_clk_gate_ctrl;

  localparam int NUM_SRC     = 4;
  localparam int IDLE_CYCLES = 16;
  localparam int WAKE_CYCLES = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ctrl_en = 1'b1;
  logic [NUM_SRC-1:0] activity = '0;
  logic               wake_req = 1'b0;
  logic               sleep_ack = 1'b0;

  logic       enable, wait_r, sleep_req, awake;
  logic [7:0] gate_cnt;
  logic       enable_s, wait_r_s, sleep_req_s, awake_s;
  logic [1:0] gate_cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dma_clk_gate_ctrl #(
    .NUM_SRC(NUM_SRC), .IDLE_CYCLES(IDLE_CYCLES), .WAKE_CYCLES(WAKE_CYCLES), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .ctrl_en(ctrl_en), .activity(activity), .wake_req(wake_req),
    .sleep_ack(sleep_ack), .enable(enable), .wait_r(wait_r), .sleep_req(sleep_req),
    .awake(awake), .gate_cnt(gate_cnt)
  );

  dma_clk_gate_ctrl #(
    .NUM_SRC(NUM_SRC), .IDLE_CYCLES(IDLE_CYCLES), .WAKE_CYCLES(WAKE_CYCLES), .CNT_W(2)
  ) dut_s (
    .clk(clk), .rst(rst), .ctrl_en(ctrl_en), .activity(activity), .wake_req(wake_req),
    .sleep_ack(sleep_ack), .enable(enable_s), .wait_r(wait_r_s), .sleep_req(sleep_req_s),
    .awake(awake_s), .gate_cnt(gate_cnt_s)
  );

  // Model: counts consecutive idle edges while awake and edges elapsed since wake.
  bit m_started = 0;
  bit m_asleep, m_req, m_waking;
  int m_idle, m_since, m_sleeps;

  task automatic model_step();
    bit ev;
    ev = (|activity) || wake_req || !ctrl_en;
    if (rst) begin
      m_started = 1; m_asleep = 0; m_req = 0; m_waking = 0;
      m_idle = 0; m_since = 0; m_sleeps = 0;
    end else if (m_waking) begin
      m_since++;
      if (m_since == WAKE_CYCLES) begin
        m_waking = 0;
        m_idle   = 0;
      end
    end else if (m_asleep) begin
      if (ev) begin
        m_asleep = 0; m_waking = 1; m_since = 0;
      end
    end else if (m_req) begin
      if (ev) begin
        m_req = 0; m_idle = 0;
      end else if (sleep_ack) begin
        m_req = 0; m_asleep = 1; m_sleeps++;
      end
    end else begin
      if (ev) m_idle = 0;
      else    m_idle++;
      if (m_idle == IDLE_CYCLES + 1) m_req = 1;
    end
  endtask

  always @(posedge clk) model_step();

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_started) begin
      chk("enable",    32'(enable),    32'(!m_asleep));
      chk("wait_r",    32'(wait_r),    32'(m_asleep || m_waking));
      chk("sleep_req", 32'(sleep_req), 32'(m_req || m_asleep));
      chk("awake",     32'(awake),     32'(!m_asleep && !m_waking));
      chk("gate_cnt",  32'(gate_cnt),  32'((m_sleeps > 255) ? 255 : m_sleeps));
      chk("enable_s",    32'(enable_s),    32'(!m_asleep));
      chk("wait_r_s",    32'(wait_r_s),    32'(m_asleep || m_waking));
      chk("sleep_req_s", 32'(sleep_req_s), 32'(m_req || m_asleep));
      chk("awake_s",     32'(awake_s),     32'(!m_asleep && !m_waking));
      chk("gate_cnt_s",  32'(gate_cnt_s),  32'((m_sleeps > 3) ? 3 : m_sleeps));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (sleep_req !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sleep_req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_req_timeout: sleep_req=%b expected 1", sleep_req);
    end
  endtask

  task automatic go_sleep();
    wait_req();
    sleep_ack = 1'b1;
    step(1);
    sleep_ack = 1'b0;
  endtask

  task automatic wake_pulse();
    wake_req = 1'b1;
    step(1);
    wake_req = 1'b0;
    step(WAKE_CYCLES);
  endtask

  initial begin
    step(2);
    rst = 1'b0;

    // Idle entry: request after edge 17, gate one edge after the ack
    step(16);
    chk("lit_req_pre",  32'(sleep_req), 32'd0);
    step(1);
    chk("lit_req_17",   32'(sleep_req), 32'd1);
    chk("lit_en_req",   32'(enable),    32'd1);
    step(1);
    sleep_ack = 1'b1;
    step(1);
    sleep_ack = 1'b0;
    chk("lit_en_sleep", 32'(enable),    32'd0);
    chk("lit_wr_sleep", 32'(wait_r),    32'd1);
    chk("lit_cnt_1",    32'(gate_cnt),  32'd1);

    // Wake: enable back at once, wait_r held for the settle window
    wake_req = 1'b1;
    step(1);
    wake_req = 1'b0;
    chk("lit_wake_en", 32'(enable), 32'd1);
    chk("lit_wake_wr", 32'(wait_r), 32'd1);
    step(3);
    chk("lit_wake_wr3", 32'(wait_r), 32'd1);
    chk("lit_wake_aw3", 32'(awake),  32'd0);
    step(1);
    chk("lit_wake_wr4", 32'(wait_r), 32'd0);
    chk("lit_wake_aw4", 32'(awake),  32'd1);

    // Reset while asleep
    go_sleep();
    chk("lit_pre_rst_en", 32'(enable), 32'd0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("lit_rst_en",  32'(enable),    32'd1);
    chk("lit_rst_wr",  32'(wait_r),    32'd0);
    chk("lit_rst_req", 32'(sleep_req), 32'd0);
    chk("lit_rst_cnt", 32'(gate_cnt),  32'd0);

    // Abort: activity and ack together in REQ
    wait_req();
    activity  = 4'b0010;
    sleep_ack = 1'b1;
    step(1);
    activity  = '0;
    sleep_ack = 1'b0;
    chk("lit_abort_req", 32'(sleep_req), 32'd0);
    chk("lit_abort_en",  32'(enable),    32'd1);
    chk("lit_abort_cnt", 32'(gate_cnt),  32'd0);

    // Idle restart after a single activity pulse
    step(10);
    activity = 4'b1000;
    step(1);
    activity = '0;
    step(16);
    chk("lit_restart_pre", 32'(sleep_req), 32'd0);
    step(1);
    chk("lit_restart_req", 32'(sleep_req), 32'd1);

    // Saturation: five sleep entries
    for (int i = 0; i < 5; i++) begin
      go_sleep();
      wake_pulse();
    end
    chk("lit_sat_cnt8", 32'(gate_cnt),   32'd5);
    chk("lit_sat_cnt2", 32'(gate_cnt_s), 32'd3);

    // Override: ctrl_en=0 while asleep wakes and holds the clock on
    go_sleep();
    ctrl_en = 1'b0;
    step(1);
    chk("lit_ovr_en", 32'(enable), 32'd1);
    chk("lit_ovr_wr", 32'(wait_r), 32'd1);
    step(WAKE_CYCLES);
    chk("lit_ovr_run_wr", 32'(wait_r), 32'd0);
    step(40);
    chk("lit_ovr_req",   32'(sleep_req), 32'd0);
    chk("lit_ovr_awake", 32'(awake),     32'd1);
    ctrl_en = 1'b1;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
